// File: rtl/sd_gen_pkg.sv
// rtl/sd_gen_pkg.sv - shared types, sizes and cell index helpers for the sudoku solver
// Purpose: FSM state enum, grid/digit sizes, cell -> row/col/box mapping and
//          digit -> one-hot mask helper used by the solver and the legality check.
// Ports:   none (package).
package sd_gen_pkg;

  localparam int GRID_CELLS = 81;
  localparam int DIGITS     = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SOLVE,
    EMIT,
    FAIL
  } state_t;

  function automatic logic [3:0] row_of(input logic [6:0] idx);
    return 4'(idx / 7'd9);
  endfunction

  function automatic logic [3:0] col_of(input logic [6:0] idx);
    return 4'(idx % 7'd9);
  endfunction

  function automatic logic [3:0] box_of(input logic [6:0] idx);
    logic [3:0] r;
    logic [3:0] c;
    r = row_of(idx);
    c = col_of(idx);
    return 4'((r / 4'd3) * 4'd3 + c / 4'd3);
  endfunction

  // One-hot bit for digits 1..9; blanks and out-of-range values give no bit.
  function automatic logic [8:0] digit_bit(input logic [3:0] v);
    if (v >= 4'd1 && v <= 4'd9) return 9'd1 << (v - 4'd1);
    else return '0;
  endfunction

endpackage

// File: rtl/sd_gen_cand.sv
// rtl/sd_gen_cand.sv - combinational legality check of one candidate digit
// Purpose: a candidate is legal when it is a digit 1..9 absent from the
//          row, column and box used masks of the cell being tried.
// Ports:   row_mask/col_mask/box_mask - 9-bit used masks (bit k = digit k+1)
//          cand                       - candidate value
//          legal                      - candidate may be placed
module sd_gen_cand
  import sd_gen_pkg::*;
(
  input  logic [8:0] row_mask,
  input  logic [8:0] col_mask,
  input  logic [8:0] box_mask,
  input  logic [3:0] cand,
  output logic       legal
);

  logic [8:0] cand_bit;

  assign cand_bit = digit_bit(cand);
  assign legal    = (cand_bit != '0) &&
                    ((cand_bit & (row_mask | col_mask | box_mask)) == '0);

endmodule

// File: rtl/sd_gen_solver.sv
// rtl/sd_gen_solver.sv - streaming 9x9 sudoku loader, backtracking solver and answer emitter
// Purpose: loads 81 cells, rejects conflicting or over-blank puzzles, solves the
//          blanks depth-first one candidate per cycle, then streams the answer.
// Ports:   clk       - clock, rising edge
//          rst_n     - synchronous active-low reset
//          in_valid  - cell strobe, 81 consecutive cycles per puzzle
//          in        - cell value, 0 = blank
//          out_valid - qualifies out / out_err
//          out       - answer digit (blank answers, or full grid when OUT_MODE=1)
//          out_err   - puzzle rejected (single cycle)
module sd_gen_solver
  import sd_gen_pkg::*;
#(
  parameter int MAX_BLANK  = 15,
  parameter int OUT_MODE   = 0,
  parameter int MAX_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in,
  output logic       out_valid,
  output logic [3:0] out,
  output logic       out_err
);

  localparam int BL_AW = (MAX_BLANK < 2) ? 1 : $clog2(MAX_BLANK);
  localparam int BL_N  = 1 << BL_AW;

  state_t state, state_next;

  logic [3:0]  grid       [GRID_CELLS];
  logic [8:0]  row_used   [DIGITS];
  logic [8:0]  col_used   [DIGITS];
  logic [8:0]  box_used   [DIGITS];
  logic [6:0]  blank_list [BL_N];
  logic [6:0]  blank_cnt;
  logic [6:0]  load_idx;
  logic [6:0]  p;
  logic [6:0]  e;
  logic        conflict;
  logic [31:0] cyc_cnt;

  // Load path: the IDLE cycle that sees in_valid already carries cell 0.
  logic [6:0] ld_idx;
  logic [3:0] ld_row, ld_col, ld_box;
  logic [8:0] ld_bit;
  logic       ld_blank, ld_dup, ld_fail, ld_last;
  logic [6:0] ld_cnt_next;

  assign ld_idx      = (state == IDLE) ? 7'd0 : load_idx;
  assign ld_row      = row_of(ld_idx);
  assign ld_col      = col_of(ld_idx);
  assign ld_box      = box_of(ld_idx);
  assign ld_bit      = digit_bit(in);
  assign ld_blank    = (in == 4'd0);
  assign ld_dup      = (in > 4'd9) ||
                       ((ld_bit & (row_used[ld_row] | col_used[ld_col] | box_used[ld_box])) != '0);
  assign ld_cnt_next = blank_cnt + {6'd0, ld_blank};
  assign ld_fail     = conflict || ld_dup || (ld_cnt_next > 7'(MAX_BLANK));
  assign ld_last     = (load_idx == 7'd80);

  // Solve path: the cell at p never has its mask bits set while it is being tried.
  logic [BL_AW-1:0] p_sel, pm1_sel;
  logic [6:0] s_idx, b_idx;
  logic [3:0] s_val, s_cand, b_val;
  logic [3:0] s_row, s_col, s_box, b_row, b_col, b_box;
  logic [8:0] s_bit, b_bit;
  logic       s_legal, s_over, s_done, s_timeout;

  assign p_sel     = BL_AW'(p);
  assign pm1_sel   = BL_AW'(p - 7'd1);
  assign s_idx     = blank_list[p_sel];
  assign s_val     = grid[s_idx];
  assign s_cand    = s_val + 4'd1;
  assign s_row     = row_of(s_idx);
  assign s_col     = col_of(s_idx);
  assign s_box     = box_of(s_idx);
  assign s_bit     = digit_bit(s_cand);
  assign s_over    = (s_cand > 4'd9);
  assign s_done    = (p == blank_cnt);
  assign s_timeout = (cyc_cnt >= 32'(MAX_CYCLES - 1));

  // Previous blank: its value is committed in the masks and must be released on step-back.
  assign b_idx = blank_list[pm1_sel];
  assign b_val = grid[b_idx];
  assign b_row = row_of(b_idx);
  assign b_col = col_of(b_idx);
  assign b_box = box_of(b_idx);
  assign b_bit = digit_bit(b_val);

  sd_gen_cand u_cand (
    .row_mask (row_used[s_row]),
    .col_mask (col_used[s_col]),
    .box_mask (box_used[s_box]),
    .cand     (s_cand),
    .legal    (s_legal)
  );

  // Emit path.
  logic [BL_AW-1:0] e_sel;
  logic [6:0] emit_len;
  logic [3:0] emit_val;
  logic       emit_last;

  assign e_sel     = BL_AW'(e);
  assign emit_len  = (OUT_MODE != 0) ? 7'd81 : ((blank_cnt == 7'd0) ? 7'd1 : blank_cnt);
  assign emit_val  = (OUT_MODE != 0) ? grid[e] :
                     ((blank_cnt == 7'd0) ? 4'd0 : grid[blank_list[e_sel]]);
  assign emit_last = (e == emit_len - 7'd1);

  logic       clear_all;
  logic       ov_d, oe_d;
  logic [3:0] o_d;

  always_comb begin
    state_next = state;
    ov_d       = 1'b0;
    o_d        = 4'd0;
    oe_d       = 1'b0;
    case (state)
      IDLE: if (in_valid) state_next = LOAD;
      LOAD: begin
        if (!in_valid) state_next = IDLE;
        else if (ld_last) begin
          if (ld_fail)                  state_next = FAIL;
          else if (ld_cnt_next == 7'd0) state_next = EMIT;
          else                          state_next = SOLVE;
        end
      end
      SOLVE: begin
        if (s_done)                     state_next = EMIT;
        else if (s_timeout)             state_next = FAIL;
        else if (s_over && p == 7'd0)   state_next = FAIL;
      end
      EMIT: begin
        ov_d = 1'b1;
        o_d  = emit_val;
        if (emit_last) state_next = IDLE;
      end
      FAIL: begin
        ov_d       = 1'b1;
        oe_d       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign clear_all = (state != IDLE) && (state_next == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear_all) begin
      for (int i = 0; i < GRID_CELLS; i++) grid[i] <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        row_used[i] <= '0;
        col_used[i] <= '0;
        box_used[i] <= '0;
      end
      for (int i = 0; i < BL_N; i++) blank_list[i] <= '0;
      blank_cnt <= '0;
      load_idx  <= '0;
      p         <= '0;
      e         <= '0;
      conflict  <= 1'b0;
      cyc_cnt   <= '0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (in_valid) begin
            grid[ld_idx] <= in;
            if (ld_blank) begin
              if (blank_cnt < 7'(MAX_BLANK)) blank_list[BL_AW'(blank_cnt)] <= ld_idx;
              blank_cnt <= ld_cnt_next;
            end else begin
              row_used[ld_row] <= row_used[ld_row] | ld_bit;
              col_used[ld_col] <= col_used[ld_col] | ld_bit;
              box_used[ld_box] <= box_used[ld_box] | ld_bit;
            end
            if (ld_dup) conflict <= 1'b1;
            load_idx <= ld_idx + 7'd1;
          end
        end
        SOLVE: begin
          cyc_cnt <= cyc_cnt + 32'd1;
          if (!s_done) begin
            if (!s_over) begin
              // An illegal candidate is still written so the next cycle tries the one after it.
              grid[s_idx] <= s_cand;
              if (s_legal) begin
                row_used[s_row] <= row_used[s_row] | s_bit;
                col_used[s_col] <= col_used[s_col] | s_bit;
                box_used[s_box] <= box_used[s_box] | s_bit;
                p <= p + 7'd1;
              end
            end else begin
              grid[s_idx] <= 4'd0;
              if (p != 7'd0) begin
                row_used[b_row] <= row_used[b_row] & ~b_bit;
                col_used[b_col] <= col_used[b_col] & ~b_bit;
                box_used[b_box] <= box_used[b_box] & ~b_bit;
                p <= p - 7'd1;
              end
            end
          end
        end
        EMIT: e <= e + 7'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= 4'd0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= ov_d;
      out       <= o_d;
      out_err   <= oe_d;
    end
  end

endmodule

// File: tb/tb_sd_gen_solver.sv
// tb/tb_sd_gen_solver.sv - directed table-driven bench for sd_gen_solver
module tb_sd_gen_solver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid0 = 1'b0;
  logic       in_valid1 = 1'b0;
  logic [3:0] in_d = 4'd0;
  logic       out_valid0, out_err0, out_valid1, out_err1;
  logic [3:0] out0, out1;

  always #5 clk = ~clk;

  sd_gen_solver #(.MAX_BLANK(15), .OUT_MODE(0), .MAX_CYCLES(200000)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in(in_d),
    .out_valid(out_valid0), .out(out0), .out_err(out_err0)
  );

  sd_gen_solver #(.MAX_BLANK(15), .OUT_MODE(1), .MAX_CYCLES(200000)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in(in_d),
    .out_valid(out_valid1), .out(out1), .out_err(out_err1)
  );

  typedef struct {
    string name;
    int    nz;
    int    zc [16];
    int    mod_cell;
    int    mod_val;
    bit    exp_err;
  } vec_t;

  int         g [81];
  logic [3:0] pz [81];
  logic [4:0] q0 [$];
  logic [4:0] q1 [$];
  vec_t       vt [7];
  int         total = 0;
  int         bad = 0;
  int         idle_bad = 0;

  always @(negedge clk) begin
    if (out_valid0) q0.push_back({out_err0, out0});
    else if (out0 != 4'd0 || out_err0) idle_bad++;
    if (out_valid1) q1.push_back({out_err1, out1});
    else if (out1 != 4'd0 || out_err1) idle_bad++;
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build(input vec_t t);
    for (int i = 0; i < 81; i++) pz[i] = 4'(g[i]);
    for (int k = 0; k < t.nz; k++) pz[t.zc[k]] = 4'd0;
    if (t.mod_cell >= 0) pz[t.mod_cell] = 4'(t.mod_val);
  endtask

  task automatic send(input int d);
    for (int i = 0; i < 81; i++) begin
      in_d = pz[i];
      if (d == 0) in_valid0 = 1'b1;
      else        in_valid1 = 1'b1;
      tick();
    end
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    in_d      = 4'd0;
  endtask

  task automatic wait_q(input int d, input int n, input string nm);
    int c;
    c = 0;
    while (qsize(d) < n && c < 6000) begin
      tick();
      c++;
    end
    if (qsize(d) < n) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d outputs required %0d", nm, qsize(d), n);
    end
    repeat (10) tick();
  endtask

  task automatic run_vec(input vec_t t);
    logic [4:0] exp_q [$];
    if (t.exp_err)      exp_q.push_back(5'h10);
    else if (t.nz == 0) exp_q.push_back(5'h00);
    else for (int k = 0; k < t.nz; k++) exp_q.push_back({1'b0, 4'(g[t.zc[k]])});
    build(t);
    q0.delete();
    send(0);
    wait_q(0, exp_q.size(), t.name);
    check($sformatf("%s_count", t.name), q0.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < q0.size(); k++)
      check($sformatf("%s_out[%0d]", t.name, k), int'(q0[k]), int'(exp_q[k]));
  endtask

  initial begin
    string gs;
    gs = {"534678912", "672195348", "198342567", "859761423", "426853791",
          "713924856", "961537284", "287419635", "345286179"};
    for (int i = 0; i < 81; i++) g[i] = int'(gs[i]) - 48;

    vt[0] = '{"g3",     3, '{0, 40, 80, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, -1, 0, 1'b0};
    vt[1] = '{"b15",   15, '{0, 3, 10, 13, 20, 23, 30, 33, 40, 43, 50, 53, 60, 70, 80, 0}, -1, 0, 1'b0};
    vt[2] = '{"b16",   16, '{0, 1, 3, 10, 13, 20, 23, 30, 33, 40, 43, 50, 53, 60, 70, 80}, -1, 0, 1'b1};
    vt[3] = '{"dup",    0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1, 5, 1'b1};
    vt[4] = '{"g3_again", 3, '{0, 40, 80, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, -1, 0, 1'b0};
    vt[5] = '{"unsolv", 2, '{0, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 9, 5, 1'b1};
    vt[6] = '{"noblank", 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, -1, 0, 1'b0};

    // Reset state.
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_out0", int'({out_valid0, out_err0, out0}), 0);
    check("reset_out1", int'({out_valid1, out_err1, out1}), 0);
    rst_n = 1'b1;

    // First puzzle starts on the first cycle after reset release.
    for (int v = 0; v < 7; v++) run_vec(vt[v]);

    // Hand-computed answers for G with cells 0, 40, 80 blank.
    build(vt[0]);
    q0.delete();
    send(0);
    wait_q(0, 3, "g3_hand");
    check("g3_hand_count", q0.size(), 3);
    if (q0.size() >= 3) begin
      check("g3_hand_0", int'(q0[0]), 5);
      check("g3_hand_1", int'(q0[1]), 5);
      check("g3_hand_2", int'(q0[2]), 9);
    end

    // Full-grid output mode.
    build(vt[1]);
    q1.delete();
    send(1);
    wait_q(1, 81, "grid81");
    check("grid81_count", q1.size(), 81);
    for (int i = 0; i < 81 && i < q1.size(); i++)
      check($sformatf("grid81[%0d]", i), int'(q1[i]), g[i]);

    // Reset pulsed while solving: no answer, then a fresh puzzle solves normally.
    build(vt[1]);
    q0.delete();
    send(0);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check("midsolve_reset_out", int'({out_valid0, out_err0, out0}), 0);
    rst_n = 1'b1;
    repeat (2000) tick();
    check("midsolve_reset_no_output", q0.size(), 0);
    build(vt[0]);
    q0.delete();
    send(0);
    wait_q(0, 3, "after_reset");
    check("after_reset_count", q0.size(), 3);
    if (q0.size() >= 3) begin
      check("after_reset_0", int'(q0[0]), 5);
      check("after_reset_1", int'(q0[1]), 5);
      check("after_reset_2", int'(q0[2]), 9);
    end

    check("idle_outputs_zero", idle_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_gen_solver.md
SD_GEN_SOLVER -- requirements
Module: sd_gen_solver

Interface
REQ-001 SHALL have parameter MAX_BLANK, default 15: max blank cells accepted per puzzle, range 1..81.
REQ-002 SHALL have parameter OUT_MODE, default 0: 0 = emit blank-cell answers only, 1 = emit full 81-cell grid.
REQ-003 SHALL have parameter MAX_CYCLES, default 200000: solve-phase cycle budget before declaring failure.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  high for exactly 81 consecutive cycles per puzzle.
REQ-007 SHALL have port in  input  4  cell value, row-major order, 0 = blank, 1..9 = clue.
REQ-008 SHALL have port out_valid  output  1  qualifies out and out_err.
REQ-009 SHALL have port out  output  4  answer digit stream.
REQ-010 SHALL have port out_err  output  1  high with out_valid when the puzzle is rejected.

Function
REQ-011 SHALL use states IDLE, LOAD, SOLVE, EMIT, FAIL.
REQ-012 IDLE->LOAD SHALL occur on the first in_valid cycle; that cell is cell 0.
REQ-013 LOAD SHALL store cells 0..80, and SHALL record each blank's index (7 bit) in a blank list in scan order.
REQ-014 LOAD SHALL update 27 nine-bit used masks (9 rows, 9 columns, 9 boxes).
REQ-015 A clue already present in its row, column or box mask SHALL set a sticky conflict flag.
REQ-016 After cell 80, LOAD SHALL go to FAIL if conflict is set or blank count > MAX_BLANK; otherwise it SHALL go to SOLVE.
REQ-017 SOLVE SHALL be depth-first backtracking over the blank list with pointer p, trying one candidate per cycle: candidate = current cell value + 1.
REQ-018 Candidate legal (absent from all three masks) SHALL write the cell, set the masks and increment p.
REQ-019 Candidate > 9 SHALL clear the cell, clear its mask bits and decrement p.
REQ-020 Stepping back onto a filled cell SHALL clear that cell's mask bits before retrying it.
REQ-021 p == blank count SHALL go to EMIT.
REQ-022 Decrement from p == 0 SHALL go to FAIL (no solution).
REQ-023 Solve-cycle counter reaching MAX_CYCLES SHALL go to FAIL.
REQ-024 Zero blanks SHALL go LOAD->EMIT directly.
REQ-025 EMIT, OUT_MODE=0: out_valid SHALL be high for exactly blank-count consecutive cycles, out = solved value of each blank in scan order, out_err = 0.
REQ-026 EMIT, OUT_MODE=0, zero blanks: one cycle with out = 0, out_err = 0.
REQ-027 EMIT, OUT_MODE=1: 81 consecutive cycles of the full grid, row-major.
REQ-028 FAIL SHALL give exactly one cycle of out_valid = 1, out = 0, out_err = 1.
REQ-029 EMIT end and FAIL SHALL return to IDLE, with all masks, cells and counters cleared on the IDLE transition.
REQ-030 out and out_err SHALL be 0 whenever out_valid = 0.
REQ-031 in_valid SHALL be ignored outside IDLE/LOAD.
REQ-032 in_valid dropping before cell 80 SHALL discard the puzzle and return to IDLE with no output.
REQ-033 First out_valid SHALL come no earlier than 1 cycle after the last in_valid cycle.

Reset
REQ-034 rst_n low at a clock edge SHALL force IDLE and clear grid, masks, blank list, counters, and out_valid/out/out_err to 0, in any state including mid-SOLVE and mid-EMIT.
REQ-035 The first puzzle SHALL be accepted on the cycle after rst_n returns high.

Structure
REQ-036 Package sd_gen_pkg SHALL hold the state enum, GRID_CELLS=81, DIGITS=9, and functions for cell-to-row/col/box index.
REQ-037 Sub-module sd_gen_cand SHALL be the combinational legality check: 3 masks plus candidate in, legal out.
REQ-038 The grid SHALL be a register array; no memories SHALL be inferred.

Verification
Reference solution G has row 0 = 5 3 4 6 7 8 9 1 2, row 4 = 4 2 6 8 5 3 7 9 1, row 8 = 3 4 5 2 8 6 1 7 9.
REQ-039 SHALL test G with cells 0, 40, 80 zeroed (OUT_MODE=0) -> exactly 3 out_valid cycles with out 5, 5, 9 and out_err 0.
REQ-040 SHALL test 16 blanks with MAX_BLANK=15 -> one cycle out_valid=1, out=0, out_err=1.
REQ-041 SHALL test a duplicate clue (two 5s in row 0) -> single error cycle; the next valid puzzle is then solved correctly.
REQ-042 SHALL test OUT_MODE=1 with G and 15 blanks -> 81 cycles matching G exactly.
REQ-043 SHALL test rst_n pulsed low mid-SOLVE -> outputs 0 next cycle, no out_valid, and a new puzzle is solved normally.
REQ-044 SHALL test an unsolvable grid with no clue conflict (a blank whose row, col and box exclude all 9 digits) -> error cycle within MAX_CYCLES.
